// File: rtl/conv2d_multi.sv
// Streaming KxK convolution with OutChannels kernels sharing one sliding window, output stride and per-channel bias.
// Optional CONV2D_MULTI_RELU_EN clamps negative channel results to zero.
module conv2d_multi #(
   parameter int LineWidthPx = 160,
   parameter int LineCountPx = 120,
   parameter int WidthIn     = 1,
   parameter int WidthOut    = 32,
   parameter int KernelWidth = 3,
   parameter int WeightWidth = 2,
   parameter int OutChannels = 4,
   parameter int Stride      = 1
) (
   input  logic                                                     clk_i,
   input  logic                                                     rst_i,
   input  logic                                                     valid_i,
   output logic                                                     ready_o,
   input  logic [WidthIn-1:0]                                       data_i,
   output logic                                                     valid_o,
   input  logic                                                     ready_i,
   output logic [OutChannels*WidthOut-1:0]                          data_o,
   input  logic [OutChannels*KernelWidth*KernelWidth*WeightWidth-1:0] weights_i,
   input  logic [OutChannels*WidthOut-1:0]                          bias_i
);

   localparam int KernelArea = KernelWidth * KernelWidth;
   localparam int XW = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
   localparam int YW = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
   localparam int SW = (Stride > 1) ? $clog2(Stride) : 1;

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [SW-1:0] r_sx;
   logic [SW-1:0] r_sy;
   logic          r_valid;

   logic w_fire;
   logic w_x_last;
   logic w_y_last;
   logic w_x_in;
   logic w_y_in;
   logic w_produce;

   assign ready_o   = ~r_valid | ready_i;
   assign valid_o   = r_valid;
   assign w_fire    = valid_i & ready_o;
   assign w_x_last  = (r_x == XW'(LineWidthPx - 1));
   assign w_y_last  = (r_y == YW'(LineCountPx - 1));
   assign w_x_in    = (r_x >= XW'(KernelWidth - 1));
   assign w_y_in    = (r_y >= YW'(KernelWidth - 1));
   assign w_produce = w_fire & w_x_in & w_y_in & (r_sx == '0) & (r_sy == '0);

   // Stride phases are forced to 0 until the first full window column/row, so
   // x==K-1 and y==K-1 always start at phase 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_x  <= '0;
         r_y  <= '0;
         r_sx <= '0;
         r_sy <= '0;
      end else if (w_fire) begin
         r_x <= w_x_last ? '0 : r_x + XW'(1);
         if (!w_x_in) r_sx <= '0;
         else         r_sx <= (r_sx == SW'(Stride - 1)) ? '0 : r_sx + SW'(1);
         if (w_x_last) begin
            r_y <= w_y_last ? '0 : r_y + YW'(1);
            if (!w_y_in) r_sy <= '0;
            else         r_sy <= (r_sy == SW'(Stride - 1)) ? '0 : r_sy + SW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)        r_valid <= 1'b0;
      else if (ready_o) r_valid <= w_produce;
   end

   // Cascaded line delays addressed by the column counter; w_tap[d] is the
   // pixel at the current column d lines ago.
   logic [WidthIn-1:0] r_line [KernelWidth-1][LineWidthPx];
   logic [WidthIn-1:0] w_tap  [KernelWidth];

   always_comb begin
      w_tap[0] = data_i;
      for (int d = 1; d < KernelWidth; d++) w_tap[d] = r_line[d-1][r_x];
   end

   // NOTE: line memories have no reset; stale contents are flushed by the
   // K-1 lines that must arrive before any window is declared valid.
   always_ff @(posedge clk_i) begin
      if (w_fire) begin
         for (int d = 0; d < KernelWidth - 1; d++) r_line[d][r_x] <= w_tap[d];
      end
   end

   logic [WidthIn-1:0] r_win [KernelWidth][KernelWidth];

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < KernelWidth; r++)
            for (int c = 0; c < KernelWidth; c++) r_win[r][c] <= '0;
      end else if (w_fire) begin
         for (int r = 0; r < KernelWidth; r++) begin
            for (int c = 0; c < KernelWidth - 1; c++) r_win[r][c] <= r_win[r][c+1];
            r_win[r][KernelWidth-1] <= w_tap[KernelWidth-1-r];
         end
      end
   end

   function automatic logic signed [WidthOut-1:0] f_term(
      input logic signed [WeightWidth-1:0] w,
      input logic        [WidthIn-1:0]     p
   );
      logic signed [WidthOut-1:0] v_w;
      logic signed [WidthOut-1:0] v_p;
      v_w = WidthOut'(w);
      v_p = WidthOut'(p);
      if (WidthIn == 1) return (p != '0) ? v_w : '0;
      return v_w * v_p;
   endfunction

   logic signed [WidthOut-1:0] w_acc [OutChannels];

   // NOTE: the accumulator is assigned before any read in every pass, so no
   // latch can be inferred.
   always_comb begin : p_mac
      logic signed [WidthOut-1:0] v_acc;
      for (int n = 0; n < OutChannels; n++) begin
         v_acc = bias_i[n*WidthOut +: WidthOut];
         for (int r = 0; r < KernelWidth; r++)
            for (int c = 0; c < KernelWidth; c++)
               v_acc = v_acc + f_term(
                  weights_i[(n*KernelArea + r*KernelWidth + c)*WeightWidth +: WeightWidth],
                  r_win[r][c]);
         w_acc[n] = v_acc;
      end
   end

   for (genvar n = 0; n < OutChannels; n++) begin : g_out
`ifdef CONV2D_MULTI_RELU_EN
      assign data_o[n*WidthOut +: WidthOut] = w_acc[n][WidthOut-1] ? '0 : w_acc[n];
`else
      assign data_o[n*WidthOut +: WidthOut] = w_acc[n];
`endif
   end

endmodule

// File: tb/tb_conv2d_multi.sv
// Scoreboard bench for conv2d_multi: a 5x5 binary instance (stride 1) and a 6x6 8-bit instance (stride 2).
// Expected results are queued by the drivers and popped by per-instance monitors when an output is accepted.
module tb_conv2d_multi;

   localparam int WO    = 16;
   localparam int StallMax = 200;

`ifdef CONV2D_MULTI_RELU_EN
   localparam int ExpNeg9  = 0;
   localparam int ExpBias0 = 0;
`else
   localparam int ExpNeg9  = -9;
   localparam int ExpBias0 = -5;
`endif

   typedef struct { int c0; int c1; } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int n_out_a = 0;
   int n_out_b = 0;
   always @(posedge clk) cyc++;

   exp_t q_a[$];
   exp_t q_b[$];

   // Instance A: 5x5 binary, stride 1
   logic          rst_a, vi_a, ro_a, vo_a, ri_a;
   logic [0:0]    di_a;
   logic [2*WO-1:0] do_a, b_a;
   logic [35:0]   w_a;
   // Instance B: 6x6 8-bit, stride 2
   logic          rst_b, vi_b, ro_b, vo_b, ri_b;
   logic [7:0]    di_b;
   logic [2*WO-1:0] do_b, b_b;
   logic [35:0]   w_b;

   conv2d_multi #(.LineWidthPx(5), .LineCountPx(5), .WidthIn(1), .WidthOut(WO), .KernelWidth(3),
                  .WeightWidth(2), .OutChannels(2), .Stride(1)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .valid_i(vi_a), .ready_o(ro_a), .data_i(di_a),
      .valid_o(vo_a), .ready_i(ri_a), .data_o(do_a), .weights_i(w_a), .bias_i(b_a));

   conv2d_multi #(.LineWidthPx(6), .LineCountPx(6), .WidthIn(8), .WidthOut(WO), .KernelWidth(3),
                  .WeightWidth(2), .OutChannels(2), .Stride(2)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .valid_i(vi_b), .ready_o(ro_b), .data_i(di_b),
      .valid_o(vo_b), .ready_i(ri_b), .data_o(do_b), .weights_i(w_b), .bias_i(b_b));

   int wa [2][9];
   int ba [2];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no response within %0d cycles", name, StallMax);
   endtask

   always @(negedge clk) begin
      if (!rst_a && vo_a && ri_a) begin
         n_out_a++;
         if (q_a.size() == 0) check("a_unexpected_output", 1, 0);
         else begin
            exp_t e;
            e = q_a.pop_front();
            check("a_ch0", int'($signed(do_a[WO-1:0])), e.c0);
            check("a_ch1", int'($signed(do_a[2*WO-1:WO])), e.c1);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_b && vo_b && ri_b) begin
         n_out_b++;
         if (q_b.size() == 0) check("b_unexpected_output", 1, 0);
         else begin
            exp_t e;
            e = q_b.pop_front();
            check("b_ch0", int'($signed(do_b[WO-1:0])), e.c0);
            check("b_ch1", int'($signed(do_b[2*WO-1:WO])), e.c1);
         end
      end
   end

   function automatic logic pix_a(input int seed, input int x, input int y);
      if (seed == 0) return 1'b0;
      if (seed == 1) return 1'b1;
      return (((x * 7) + (y * 3) + seed) % 5) < 2;
   endfunction

   // Reference: spatial window with top-left at (x-2,y-2), weight index r*3+c.
   function automatic int ref_a(input int n, input int seed, input int x, input int y);
      int acc;
      acc = ba[n];
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            if (pix_a(seed, x - 2 + c, y - 2 + r)) acc += wa[n][r*3 + c];
`ifdef CONV2D_MULTI_RELU_EN
      if (acc < 0) acc = 0;
`endif
      return acc;
   endfunction

   task automatic apply_a();
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < 9; i++) w_a[(n*9 + i)*2 +: 2] = 2'(wa[n][i]);
         b_a[n*WO +: WO] = WO'(ba[n]);
      end
   endtask

   task automatic push_a(input logic p);
      int t;
      t = 0;
      vi_a = 1'b1;
      di_a = p;
      do begin @(negedge clk); t++; end while (!ro_a && t < StallMax);
      if (!ro_a) timeout("a_input_stall");
      @(posedge clk); #1;
      vi_a = 1'b0;
   endtask

   task automatic push_b(input logic [7:0] p);
      int t;
      t = 0;
      vi_b = 1'b1;
      di_b = p;
      do begin @(negedge clk); t++; end while (!ro_b && t < StallMax);
      if (!ro_b) timeout("b_input_stall");
      @(posedge clk); #1;
      vi_b = 1'b0;
   endtask

   task automatic send_frame_a(input int seed, input int npix);
      for (int i = 0; i < npix; i++) begin
         int x, y;
         x = i % 5;
         y = i / 5;
         if (x >= 2 && y >= 2) q_a.push_back('{ref_a(0, seed, x, y), ref_a(1, seed, x, y)});
         push_a(pix_a(seed, x, y));
      end
   endtask

   task automatic bp_stall();
      int t;
      logic [2*WO-1:0] held;
      t = 0;
      while (!vo_a && t < StallMax) begin @(posedge clk); #1; t++; end
      if (!vo_a) timeout("bp_wait_output");
      else begin
         ri_a = 1'b0;
         held = do_a;
         repeat (10) begin
            @(negedge clk);
            check("bp_ready_o_low", ro_a, 0);
            check("bp_valid_held", vo_a, 1);
            check("bp_data_held", do_a, held);
         end
         @(posedge clk); #1;
         ri_a = 1'b1;
      end
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0, o0;
      rst_a = 1'b1; rst_b = 1'b1;
      vi_a = 1'b0; vi_b = 1'b0; di_a = '0; di_b = '0;
      ri_a = 1'b1; ri_b = 1'b1;
      w_a = '0; b_a = '0; w_b = '0; b_b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("reset_valid_a", vo_a, 0);
      check("reset_ready_a", ro_a, 1);
      check("reset_valid_b", vo_b, 0);
      check("reset_ready_b", ro_b, 1);
      @(posedge clk); #1;

      // Stride 2, 8-bit pixels x+10y: ch0 centre tap, ch1 = 100 - top-left pixel
      w_b = '0;
      w_b[4*2 +: 2]     = 2'sd1;
      w_b[(9+0)*2 +: 2] = -2'sd1;
      b_b[WO-1:0]       = WO'(0);
      b_b[2*WO-1:WO]    = WO'(100);
      q_b.push_back('{11, 100});
      q_b.push_back('{13, 98});
      q_b.push_back('{31, 80});
      q_b.push_back('{33, 78});
      for (int y = 0; y < 6; y++)
         for (int x = 0; x < 6; x++) push_b(8'(x + 10 * y));
      drain(5);
      check("b_output_count", n_out_b, 4);

      // All-ones binary frame: ch0 +1 weights, ch1 -1 weights
      for (int i = 0; i < 9; i++) begin wa[0][i] = 1; wa[1][i] = -1; end
      ba[0] = 0; ba[1] = 0;
      apply_a();
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++) begin
            if (x >= 2 && y >= 2) q_a.push_back('{9, ExpNeg9});
            push_a(1'b1);
            check("a_valid_timing", vo_a, (x >= 2 && y >= 2) ? 1 : 0);
         end
      drain(3);
      check("a_ones_count", n_out_a, 9);

      // Bias only: zero frame
      ba[0] = -5; ba[1] = 3;
      apply_a();
      for (int i = 0; i < 25; i++) begin
         if (i % 5 >= 2 && i / 5 >= 2) q_a.push_back('{ExpBias0, 3});
         push_a(1'b0);
      end
      drain(3);

      // Patterned frame with asymmetric ch1 kernel under backpressure
      wa[1] = '{1, -1, 0, 0, 1, -2, -1, 0, 1};
      ba[0] = 0; ba[1] = 1;
      apply_a();
      fork
         send_frame_a(2, 25);
         bp_stall();
      join
      drain(3);

      // Reset mid-frame just before pixel (3,2), then a full fresh frame
      send_frame_a(3, 13);
      drain(3);
      rst_a = 1'b1;
      drain(2);
      @(negedge clk);
      check("midframe_reset_valid", vo_a, 0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      send_frame_a(4, 25);
      drain(3);

      // Two back-to-back frames at one pixel per cycle
      o0 = n_out_a;
      c0 = cyc;
      send_frame_a(2, 25);
      send_frame_a(2, 25);
      check("b2b_cycles", cyc - c0, 50);
      drain(3);
      check("b2b_output_count", n_out_a - o0, 18);

      check("a_queue_empty", q_a.size(), 0);
      check("b_queue_empty", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
